fib_seq: RTL and testbench

Parametrised successor to the single-result Fibonacci calculator. It computes a generalised Fibonacci sequence with programmable seeds, F(0)=seed0, F(1)=seed1, F(k)=F(k-1)+F(k-2) mod 2^OUTPUT_WIDTH. It runs in one of two modes: single-result, or streaming every term F(0)..F(n) over a valid/ready handshake with backpressure. It sits in the lab datapath as a self-contained sequential core driven by a go/done controller or a downstream stream consumer.

---
 rtl/fib_pkg.sv | 15 +
 rtl/fib_seq_dp.sv | 52 +++++
 rtl/fib_seq.sv | 90 +++++++++
 tb/tb_fib_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types for the generalised Fibonacci sequencer: FSM state codes and run mode.
package fib_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    typedef enum logic {
        FIB_MODE_SINGLE = 1'b0,
        FIB_MODE_STREAM = 1'b1
    } mode_t;

endpackage

// File: rtl/fib_seq_dp.sv
// Fibonacci datapath: a = F(k), b = F(k+1), term counter k and the sticky
// overflow flag, driven by load/advance strobes from the controller.
module fib_seq_dp #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    advance,
    input  logic [OUTPUT_WIDTH-1:0] seed0,
    input  logic [OUTPUT_WIDTH-1:0] seed1,
    input  logic [INPUT_WIDTH-1:0]  n_last,
    output logic [OUTPUT_WIDTH-1:0] a,
    output logic [INPUT_WIDTH-1:0]  k,
    output logic                    overflow
);

    logic [OUTPUT_WIDTH-1:0] b;
    logic [OUTPUT_WIDTH:0]   sum;
    logic                    in_range;

    assign sum = {1'b0, a} + {1'b0, b};

    // The sum being produced is F(k+2); a carry only counts if that term is
    // part of this run. One extra bit keeps k+2 from wrapping near the top of n.
    assign in_range = ({1'b0, k} + (INPUT_WIDTH + 1)'(2)) <= {1'b0, n_last};

    // NOTE: all state here is updated with non-blocking assignments so a and b
    // swap/advance on the same edge without ordering hazards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a        <= '0;
            b        <= '0;
            k        <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            a        <= seed0;
            b        <= seed1;
            k        <= '0;
            overflow <= 1'b0;
        end else if (advance) begin
            a <= b;
            b <= sum[OUTPUT_WIDTH-1:0];
            k <= k + INPUT_WIDTH'(1);
            if (sum[OUTPUT_WIDTH] && in_range) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fib_seq.sv
// Generalised Fibonacci sequencer with programmable seeds: single-result mode or
// streaming F(0)..F(n) over a valid/ready handshake with backpressure.
module fib_seq
    import fib_pkg::*;
#(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    go,
    input  logic [INPUT_WIDTH-1:0]  n,
    input  logic [OUTPUT_WIDTH-1:0] seed0,
    input  logic [OUTPUT_WIDTH-1:0] seed1,
    input  logic                    mode,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [OUTPUT_WIDTH-1:0] result,
    output logic [INPUT_WIDTH-1:0]  term_idx,
    output logic                    overflow,
    output logic                    busy,
    output logic                    done
);

    state_t                  state;
    mode_t                   mode_r;
    logic [INPUT_WIDTH-1:0]  n_r;
    logic [OUTPUT_WIDTH-1:0] result_r;
    logic [OUTPUT_WIDTH-1:0] a;
    logic [INPUT_WIDTH-1:0]  k;
    logic                    running;
    logic                    stream_run;
    logic                    at_last;
    logic                    step;
    logic                    accept;
    logic                    advance;
    logic                    finish;

    assign running    = (state == RUN);
    assign stream_run = running && (mode_r == FIB_MODE_STREAM);
    assign at_last    = (k == n_r);
    // A step is taken every RUN cycle in single mode, only on a handshake in stream mode.
    assign step       = running && ((mode_r == FIB_MODE_SINGLE) || out_ready);
    assign accept     = go && !running;
    assign advance    = step && !at_last;
    assign finish     = step && at_last;

    assign busy      = running;
    assign out_valid = stream_run;
    assign out_last  = stream_run && at_last;
    assign result    = stream_run ? a : result_r;
    assign term_idx  = k;

    fib_seq_dp #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .OUTPUT_WIDTH(OUTPUT_WIDTH)
    ) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .advance (advance),
        .seed0   (seed0),
        .seed1   (seed1),
        .n_last  (n_r),
        .a       (a),
        .k       (k),
        .overflow(overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode_r   <= FIB_MODE_SINGLE;
            n_r      <= '0;
            result_r <= '0;
            done     <= 1'b0;
        end else if (accept) begin
            state  <= RUN;
            mode_r <= mode_t'(mode);
            n_r    <= n;
            done   <= 1'b0;
        end else if (finish) begin
            state    <= DONE;
            result_r <= a;
            done     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fib_seq.sv
// Scoreboard bench for fib_seq: a reference sequence model pushes expected terms
// and completions; an independent monitor pops and compares them.
module tb_fib_seq;

    localparam int IW = 6;
    localparam int OW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic          mode = 1'b0;
    logic          out_ready = 1'b0;
    logic [IW-1:0] n = '0;
    logic [OW-1:0] seed0 = '0;
    logic [OW-1:0] seed1 = '0;
    logic          out_valid;
    logic          out_last;
    logic          overflow;
    logic          busy;
    logic          done;
    logic [OW-1:0] result;
    logic [IW-1:0] term_idx;

    int vectors = 0;
    int errors  = 0;
    bit ready_rand = 1'b1;

    typedef struct {
        bit            is_done;
        logic [OW-1:0] value;
        logic [IW-1:0] idx;
        bit            last;
        bit            ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fib_seq #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .n        (n),
        .seed0    (seed0),
        .seed1    (seed1),
        .mode     (mode),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_last (out_last),
        .result   (result),
        .term_idx (term_idx),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain sequence arithmetic from the seeds, wide sums for carries.
    task automatic push_run(input int nn, input logic [OW-1:0] s0, input logic [OW-1:0] s1,
                            input bit strm, output logic [OW-1:0] fin, output bit ovf);
        logic [OW-1:0] f[$];
        logic [OW:0]   s;
        ovf = 1'b0;
        f.push_back(s0);
        f.push_back(s1);
        for (int j = 2; j <= nn; j++) begin
            s = {1'b0, f[j-1]} + {1'b0, f[j-2]};
            if (s[OW]) ovf = 1'b1;
            f.push_back(s[OW-1:0]);
        end
        if (strm)
            for (int j = 0; j <= nn; j++)
                sb.push_back('{1'b0, f[j], IW'(j), (j == nn), 1'b0});
        fin = f[nn];
        sb.push_back('{1'b1, f[nn], IW'(nn), 1'b1, ovf});
    endtask

    // Monitor: compares every presented stream term and every completion.
    bit done_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_prev = 1'b0;
            end else begin
                if (out_valid) begin
                    if (sb.size() == 0 || sb[0].is_done) begin
                        check("unexpected_valid", out_valid, 1'b0);
                    end else begin
                        check("term_value", result, sb[0].value);
                        check("term_idx", term_idx, sb[0].idx);
                        check("term_last", out_last, sb[0].last);
                        if (out_ready) void'(sb.pop_front());
                    end
                end
                if (done && !done_prev) begin
                    if (sb.size() == 0 || !sb[0].is_done) begin
                        check("unexpected_done", done, 1'b0);
                    end else begin
                        check("done_result", result, sb[0].value);
                        check("done_term_idx", term_idx, sb[0].idx);
                        check("done_overflow", overflow, sb[0].ovf);
                        void'(sb.pop_front());
                    end
                end
                done_prev = done;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? ($urandom_range(0, 99) < 60) : 1'b1;
        end
    end

    task automatic scramble();
        n     = IW'($urandom);
        seed0 = $urandom;
        seed1 = $urandom;
        mode  = 1'($urandom);
    endtask

    // One complete run; inputs are scrambled once go has been accepted.
    task automatic run(input int nn, input logic [OW-1:0] s0, input logic [OW-1:0] s1,
                       input bit strm, input bit poke_go, input longint want);
        logic [OW-1:0] fin;
        bit            ovf;
        int            lat;
        push_run(nn, s0, s1, strm, fin, ovf);
        n = IW'(nn); seed0 = s0; seed1 = s1; mode = strm; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        check("busy_after_go", busy, 1'b1);
        scramble();
        if (poke_go && nn >= 2) go = 1'b1;
        lat = 0;
        while (!done && lat < 500) begin
            @(posedge clk); #1;
            lat++;
            go = 1'b0;
            scramble();
        end
        check("done_seen", done, 1'b1);
        if (!strm || !ready_rand) check("latency", lat, nn + 1);
        if (want >= 0) check("known_value", result, want[OW-1:0]);
        repeat (2) @(posedge clk);
        #1;
        check("hold_done", done, 1'b1);
        check("hold_result", result, fin);
        check("hold_overflow", overflow, ovf);
        check("hold_busy", busy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, result, 0);
        check({tag, "_term_idx"}, term_idx, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic reset_mid(input bit strm);
        logic [OW-1:0] fin;
        bit            ovf;
        push_run(20, 3, 4, strm, fin, ovf);
        n = IW'(20); seed0 = 3; seed1 = 4; mode = strm; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(strm ? "rst_stream" : "rst_single");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int rises, highs, cyc;
        bit prev;
        logic [OW-1:0] fin;
        bit ovf;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(10, 0, 1, 1'b0, 1'b0, 55);
        run(0, 0, 1, 1'b0, 1'b0, 0);
        run(1, 0, 1, 1'b0, 1'b0, 1);
        run(5, 2, 1, 1'b0, 1'b0, 11);
        run(47, 0, 1, 1'b0, 1'b0, 64'd2971215073);
        check("ovf_n47", overflow, 1'b0);
        run(48, 0, 1, 1'b0, 1'b0, 64'd512559680);
        check("ovf_n48", overflow, 1'b1);
        run(10, 0, 1, 1'b0, 1'b0, 55);
        check("ovf_cleared", overflow, 1'b0);

        ready_rand = 1'b1;
        run(6, 0, 1, 1'b1, 1'b0, 8);
        ready_rand = 1'b0;
        run(6, 0, 1, 1'b1, 1'b0, 8);
        run(0, 9, 4, 1'b1, 1'b0, 9);
        ready_rand = 1'b1;

        run(12, 0, 1, 1'b0, 1'b1, 144);
        run(9, 0, 1, 1'b1, 1'b1, 34);

        // go held high: three back-to-back runs, each done lasting one cycle
        for (int r = 0; r < 3; r++) push_run(2, 5, 7, 1'b0, fin, ovf);
        n = IW'(2); seed0 = 5; seed1 = 7; mode = 1'b0; go = 1'b1;
        rises = 0; highs = 0; cyc = 0; prev = done;
        while (rises < 3 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done) highs++;
            if (done && !prev) rises++;
            prev = done;
        end
        go = 1'b0;
        check("held_go_runs", rises, 3);
        check("held_go_done_cycles", highs, 3);
        check("held_go_result", result, 12);
        repeat (2) @(posedge clk);

        reset_mid(1'b0);
        reset_mid(1'b1);
        run(10, 0, 1, 1'b0, 1'b0, 55);

        for (int r = 0; r < 20; r++) begin
            ready_rand = 1'($urandom_range(0, 3) != 0);
            run(int'($urandom_range(0, 50)), $urandom, $urandom, 1'($urandom), 1'($urandom), -1);
        end

        repeat (2) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
